// File: rtl/sdram_frame_arb.sv
// Frame-buffer scheduler for the OV7670 capture path: arbitrates full-page SDRAM
// bursts between the camera write FIFO and the display read FIFO, ping-ponging two banks.
module sdram_frame_arb #(
  parameter int BURST_LEN      = 512,
  parameter int ROWS_PER_FRAME = 150,
  parameter int FIFO_DEPTH     = 1024,
  parameter int USEDW_W        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [USEDW_W-1:0] wfifo_usedw,
  input  logic [15:0]        wfifo_q,
  output logic               wfifo_rdreq,
  input  logic [USEDW_W-1:0] rfifo_usedw,
  output logic               rfifo_wrreq,
  output logic [15:0]        rfifo_data,
  output logic               sd_wr_req,
  output logic               sd_rd_req,
  input  logic               sd_wr_ack,
  input  logic               sd_rd_ack,
  output logic [15:0]        sd_wdata,
  input  logic [15:0]        sd_rdata,
  input  logic               sd_rdata_vld,
  output logic [1:0]         sd_bank,
  output logic [12:0]        sd_addr,
  output logic               wr_frame_done,
  output logic               frame_drop,
  output logic [2:0]         dbg_state
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0]      BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [12:0]        ROW_LAST  = 13'(ROWS_PER_FRAME - 1);
  localparam logic [USEDW_W:0]   WR_THRESH = (USEDW_W + 1)'(BURST_LEN);
  localparam logic [USEDW_W:0]   RD_LIMIT  = (USEDW_W + 1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [12:0]   wr_row_q, wr_row_d;
  logic [12:0]   rd_row_q, rd_row_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          done_bank_q, done_bank_d;
  logic          frame_avail_q, frame_avail_d;
  logic          last_wr_q, last_wr_d;
  logic          wdata_vld_q, wdata_vld_d;
  logic          wr_ready, rd_ready;

  // Request/grant: a request and its bank/row stay asserted and stable until the
  // one-cycle ack; the burst starts in the ack cycle itself.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    wr_row_d      = wr_row_q;
    rd_row_d      = rd_row_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    done_bank_d   = done_bank_q;
    frame_avail_d = frame_avail_q;
    last_wr_d     = last_wr_q;
    wfifo_rdreq   = 1'b0;
    rfifo_wrreq   = 1'b0;
    sd_wr_req     = 1'b0;
    sd_rd_req     = 1'b0;
    sd_bank       = 2'd0;
    sd_addr       = 13'd0;
    wr_frame_done = 1'b0;
    frame_drop    = 1'b0;

    wr_ready = {1'b0, wfifo_usedw} >= WR_THRESH;
    rd_ready = rd_en && frame_avail_q && ({1'b0, rfifo_usedw} <= RD_LIMIT);

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        // On a tie the side that did not win last time goes next.
        if (wr_ready && (!rd_ready || !last_wr_q)) begin
          state_d = ST_WR_REQ;
        end else if (rd_ready) begin
          state_d = ST_RD_REQ;
          if (rd_row_q == 13'd0) rd_bank_d = done_bank_q;
        end
      end
      ST_WR_REQ: begin
        sd_wr_req = 1'b1;
        sd_bank   = {1'b0, wr_bank_q};
        sd_addr   = wr_row_q;
        if (sd_wr_ack) begin
          wfifo_rdreq = 1'b1;
          beat_d      = BW'(1);
          state_d     = ST_WR_BURST;
        end
      end
      ST_WR_BURST: begin
        wfifo_rdreq = 1'b1;
        beat_d      = beat_q + BW'(1);
        if (beat_q == BEAT_LAST) begin
          state_d   = ST_IDLE;
          last_wr_d = 1'b1;
          if (wr_row_q == ROW_LAST) begin
            wr_row_d      = 13'd0;
            wr_frame_done = 1'b1;
            // Only hand the frame over while the reader sits between frames.
            if (rd_row_q == 13'd0) begin
              done_bank_d   = wr_bank_q;
              wr_bank_d     = ~wr_bank_q;
              frame_avail_d = 1'b1;
            end else begin
              frame_drop = 1'b1;
            end
          end else begin
            wr_row_d = wr_row_q + 13'd1;
          end
        end
      end
      ST_RD_REQ: begin
        sd_rd_req = 1'b1;
        sd_bank   = {1'b0, rd_bank_q};
        sd_addr   = rd_row_q;
        if (sd_rd_ack) begin
          beat_d  = '0;
          state_d = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        rfifo_wrreq = sd_rdata_vld;
        if (sd_rdata_vld) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == BEAT_LAST) begin
            state_d   = ST_IDLE;
            last_wr_d = 1'b0;
            rd_row_d  = (rd_row_q == ROW_LAST) ? 13'd0 : rd_row_q + 13'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO data follows rdreq by one cycle, so the write data window is rdreq delayed.
  assign wdata_vld_d = wfifo_rdreq;
  assign sd_wdata    = wdata_vld_q ? wfifo_q : 16'd0;
  assign rfifo_data  = rfifo_wrreq ? sd_rdata : 16'd0;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      wr_row_q      <= 13'd0;
      rd_row_q      <= 13'd0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      done_bank_q   <= 1'b0;
      frame_avail_q <= 1'b0;
      last_wr_q     <= 1'b0;
      wdata_vld_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wr_row_q      <= wr_row_d;
      rd_row_q      <= rd_row_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      done_bank_q   <= done_bank_d;
      frame_avail_q <= frame_avail_d;
      last_wr_q     <= last_wr_d;
      wdata_vld_q   <= wdata_vld_d;
    end
  end

endmodule

// File: doc/sdram_frame_arb.md
Name: sdram_frame_arb

Overview:
- Frame-buffer scheduler above the SDRAM command interface in the OV7670 capture path.
- Arbitrates full-page bursts between the camera write FIFO and the display read FIFO, and issues one request at a time.
- Generates bank/row addresses and runs a two-bank ping-pong buffer so the display always reads a completed frame.

Parameters:
- BURST_LEN, 512, words per burst (full page); the interface holds WRITE/READ for exactly this many cycles.
- ROWS_PER_FRAME, 150, pages per frame (320x240x16b / 512).
- FIFO_DEPTH, 1024, depth of each external FIFO.
- USEDW_W, 10, width of the FIFO fill-level inputs.

Ports:
- clk in 1: system clock, same clock as the SDRAM interface.
- rst_n in 1: asynchronous, active-low reset.
- rd_en in 1: display enable; gates new read bursts.
- wfifo_usedw in USEDW_W: camera write-FIFO fill level.
- wfifo_q in 16: write-FIFO data; normal mode, valid 1 cycle after rdreq.
- wfifo_rdreq out 1: write-FIFO pop.
- rfifo_usedw in USEDW_W: display read-FIFO fill level.
- rfifo_wrreq out 1: read-FIFO push.
- rfifo_data out 16: read-FIFO data.
- sd_wr_req out 1: write request to the interface.
- sd_rd_req out 1: read request to the interface.
- sd_wr_ack in 1: 1-cycle write grant.
- sd_rd_ack in 1: 1-cycle read grant.
- sd_wdata out 16: write data to the interface.
- sd_rdata in 16: read data from the interface.
- sd_rdata_vld in 1: read data valid.
- sd_bank out 2: bank for the current request.
- sd_addr out 13: row for the current request.
- wr_frame_done out 1: 1-cycle pulse at each completed write frame.
- frame_drop out 1: 1-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0; wr_bank=0, rd_bank=1, done_bank=0, frame_avail=0, wr_row=0, rd_row=0, last_grant=read (so the first tie goes to write).
- Reset mid-burst aborts immediately; the FIFOs and the interface are assumed reset by the same rst_n.
- FSM states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
- Request conditions:
  - wr_ready = wfifo_usedw >= BURST_LEN.
  - rd_ready = rd_en && frame_avail && rfifo_usedw <= FIFO_DEPTH-BURST_LEN.
- IDLE transitions:
  - Only wr_ready: go to WR_REQ.
  - Only rd_ready: go to RD_REQ.
  - Both: grant the opposite of last_grant. The grant is decided in IDLE only.
- WR_REQ:
  - sd_wr_req=1 and sd_bank=wr_bank, sd_addr=wr_row, all held stable until sd_wr_ack.
  - On sd_wr_ack: drop sd_wr_req the next cycle and go to WR_BURST.
- WR_BURST:
  - wfifo_rdreq=1 for exactly BURST_LEN cycles, starting in the sd_wr_ack cycle; beat counter 0..BURST_LEN-1.
  - sd_wdata = wfifo_q, combinational passthrough, so word k lands on WRITE cycle k.
  - On the last beat: go to IDLE and set last_grant=write.
  - wr_row increments by 1; at ROWS_PER_FRAME-1 it wraps to 0 and a frame end occurs.
- Write frame end:
  - Pulse wr_frame_done.
  - If rd_row==0 (reader between frames): done_bank<=wr_bank, wr_bank<=~wr_bank, frame_avail<=1.
  - Otherwise: pulse frame_drop and keep wr_bank; the next frame overwrites it.
- RD_REQ:
  - On entry with rd_row==0: rd_bank<=done_bank first.
  - sd_rd_req=1 and sd_bank=rd_bank, sd_addr=rd_row, held until sd_rd_ack, then go to RD_BURST.
- RD_BURST:
  - rfifo_wrreq=sd_rdata_vld and rfifo_data=sd_rdata, passthrough.
  - Count vld beats; after BURST_LEN beats go to IDLE and set last_grant=read.
  - rd_row increments and wraps at ROWS_PER_FRAME-1. The same bank is re-read if no newer frame exists.
- Mutual exclusion: sd_wr_req and sd_rd_req are never 1 in the same cycle.
- Bank/address outside a REQ state: sd_bank and sd_addr are 0.
- rd_en falling mid-burst: finish the burst; rd_row is kept.
- Requests during SDRAM init or refresh simply stall in the REQ states; there is no timeout.
- A stray ack outside the matching REQ state is ignored.
- Bank values are limited to 0/1; bit 1 of sd_bank is always 0.
- Counter widths: beat counter log2(BURST_LEN)+1 bits, row counters 13 bits.

Test Plan:
- Write grant: wfifo_usedw=512, rfifo/rd idle, ack after 7 cycles -> sd_wr_req high for 7 cycles with bank0/row0; wfifo_rdreq high for exactly 512 cycles starting at ack; sd_wdata equals wfifo_q.
- Read after frame: complete 150 write bursts -> wr_frame_done pulses once, wr_bank=1, frame_avail=1. Then rd_en=1 with rfifo_usedw=0 -> read issued on bank0 row0; 512 vld beats produce 512 rfifo_wrreq; rd_row=1.
- Round-robin: both ready continuously -> grants alternate W,R,W,R; no cycle has both sd_wr_req and sd_rd_req high.
- Frame drop: reader at rd_row=40 when a write frame ends -> frame_drop pulses, wr_bank unchanged, done_bank unchanged.
- Back-pressure: rfifo_usedw=513 -> no read request. wfifo_usedw=511 -> no write request. At 512 -> request next cycle.
- Reset mid-WR_BURST at beat 200 -> all outputs 0 immediately. After release, the next write is to bank0 row0.
